// File: rtl/poly1305_mac_ctrl_pkg.sv
// Shared widths, constants, FSM encoding and the final-reduction helper for the
// Poly1305 MAC controller.
package poly1305_mac_ctrl_pkg;

   localparam int ACC_W       = 130;
   localparam int M_W         = 129;
   localparam int BLOCK_BYTES = 16;

   localparam logic [ACC_W-1:0] P            = {ACC_W{1'b1}} - ACC_W'(4);
   localparam logic [127:0]     R_CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_MSG,
      ISSUE,
      WAIT_PB,
      FINAL,
      TAG
   } state_t;

   // acc is below 2^130, so a single conditional subtract of P fully reduces it.
   function automatic logic [127:0] final_tag(input logic [ACC_W-1:0] acc,
                                              input logic [127:0]     s);
      logic [ACC_W-1:0] red;
      red = (acc >= P) ? acc - P : acc;
      return red[127:0] + s;
   endfunction

endpackage

// File: rtl/poly1305_mac_ctrl_if.sv
// Host-side key, message-block and tag streams of the MAC controller.
// Valid/ready on every stream; the controller is the slave.
interface poly1305_mac_ctrl_if;

   logic         key_valid;
   logic [255:0] key;
   logic         key_ready;

   logic         msg_valid;
   logic [127:0] msg_data;
   logic [4:0]   msg_bytes;
   logic         msg_last;
   logic         msg_ready;

   logic         tag_valid;
   logic [127:0] tag;
   logic         tag_ready;

   modport master (
      output key_valid, key, msg_valid, msg_data, msg_bytes, msg_last, tag_ready,
      input  key_ready, msg_ready, tag_valid, tag
   );

   modport slave (
      input  key_valid, key, msg_valid, msg_data, msg_bytes, msg_last, tag_ready,
      output key_ready, msg_ready, tag_valid, tag
   );

endinterface

// File: rtl/poly1305_mac_ctrl_msg_pad.sv
// Pads a message block: keeps the low n bytes, sets bit 8n, clears the rest.
// Purely combinational; bad_len flags a byte count above one block.
module poly1305_msg_pad
   import poly1305_mac_ctrl_pkg::*;
(
   input  logic [127:0]   data,
   input  logic [4:0]     bytes,
   output logic [M_W-1:0] m,
   output logic           bad_len
);

   assign bad_len = (bytes > 5'(BLOCK_BYTES));

   always_comb begin
      m = '0;
      for (int k = 0; k < BLOCK_BYTES; k++) begin
         if (5'(k) < bytes) begin
            m[8*k +: 8] = data[8*k +: 8];
         end
      end
      if (!bad_len) begin
         m[{bytes, 3'b000}] = 1'b1;
      end
   end

endmodule

// File: rtl/poly1305_mac_ctrl.sv
// Sequences one Poly1305 MAC around an external multiply/reduce core; owns acc.
// Tag valid two cycles after the last core done; tag held until consumed.
module poly1305_mac_ctrl
   import poly1305_mac_ctrl_pkg::*;
#(
   parameter int WDOG_CYCLES = 1024
)
(
   input  logic                  clk,
   input  logic                  rst_ni,
   poly1305_mac_ctrl_if.slave    host,
   output logic                  pb_start_o,
   output logic [127:0]          pb_r_o,
   output logic [M_W-1:0]        pb_m_o,
   output logic [ACC_W-1:0]      pb_a_o,
   input  logic [ACC_W-1:0]      pb_a_i,
   input  logic                  pb_done_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

   state_t             state;
   logic [127:0]       r;
   logic [127:0]       s;
   logic [ACC_W-1:0]   acc;
   logic [M_W-1:0]     m;
   logic               last;
   logic [WD_W-1:0]    wdog;
   logic               key_rdy;
   logic               msg_rdy;
   logic               pb_start;
   logic               tag_vld;
   logic [127:0]       tag;
   logic               err;

   logic [M_W-1:0]     pad_m;
   logic               bad_len;

   poly1305_msg_pad u_pad (
      .data    (host.msg_data),
      .bytes   (host.msg_bytes),
      .m       (pad_m),
      .bad_len (bad_len)
   );

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         r        <= '0;
         s        <= '0;
         acc      <= '0;
         m        <= '0;
         last     <= 1'b0;
         wdog     <= '0;
         key_rdy  <= 1'b0;
         msg_rdy  <= 1'b0;
         pb_start <= 1'b0;
         tag_vld  <= 1'b0;
         tag      <= '0;
         err      <= 1'b0;
      end else begin
         pb_start <= 1'b0;
         case (state)
            IDLE: begin
               key_rdy <= 1'b1;
               if (host.key_valid && key_rdy) begin
                  r       <= host.key[127:0] & R_CLAMP_MASK;
                  s       <= host.key[255:128];
                  acc     <= '0;
                  err     <= 1'b0;
                  key_rdy <= 1'b0;
                  msg_rdy <= 1'b1;
                  state   <= WAIT_MSG;
               end
            end
            WAIT_MSG: begin
               if (host.msg_valid && msg_rdy) begin
                  msg_rdy <= 1'b0;
                  last    <= host.msg_last;
                  if (host.msg_bytes == '0 && host.msg_last) begin
                     state <= FINAL;
                  end else if (bad_len ||
                               (host.msg_bytes < 5'(BLOCK_BYTES) && !host.msg_last)) begin
                     // Only the final block may be short; anything else aborts.
                     err     <= 1'b1;
                     key_rdy <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     m        <= pad_m;
                     pb_start <= 1'b1;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               wdog  <= '0;
               state <= WAIT_PB;
            end
            WAIT_PB: begin
               if (pb_done_i) begin
                  acc <= pb_a_i;
                  if (last) begin
                     state <= FINAL;
                  end else begin
                     msg_rdy <= 1'b1;
                     state   <= WAIT_MSG;
                  end
               end else if (wdog == WD_W'(WDOG_CYCLES - 1)) begin
                  err     <= 1'b1;
                  key_rdy <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            FINAL: begin
               tag     <= final_tag(acc, s);
               tag_vld <= 1'b1;
               state   <= TAG;
            end
            TAG: begin
               if (host.tag_ready && tag_vld) begin
                  tag_vld <= 1'b0;
                  key_rdy <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign host.key_ready = key_rdy;
   assign host.msg_ready = msg_rdy;
   assign host.tag_valid = tag_vld;
   assign host.tag       = tag;

   assign pb_start_o = pb_start;
   assign pb_r_o     = r;
   assign pb_m_o     = m;
   assign pb_a_o     = acc;
   assign busy_o     = (state != IDLE);
   assign err_o      = err;

endmodule

// File: doc/poly1305_mac_ctrl.md
Name: poly1305_mac_ctrl

Overview:
- Sequences one Poly1305 MAC computation around the existing one-block multiply/reduce datapath (the external "processblock" core).
- Accepts a 256-bit one-time key, then a stream of 16-byte message blocks.
- Per block: clamps r, pads the block, issues one multiply, and captures the accumulator. After the last block it applies the final reduction mod P and adds s to produce the 128-bit tag.
- Sits between the host/stream interface and the processblock core; owns the accumulator register.

Parameters:
- WDOG_CYCLES, 1024, maximum cycles to wait for pb_done_i before flagging an error.

Ports:
- clk  input  1  clock, all flops on rising edge
- rst_ni  input  1  asynchronous active-low reset
- key_valid_i  input  1  key offered
- key_i  input  256  little-endian key; r = [127:0], s = [255:128]
- key_ready_o  output  1  controller accepts key (IDLE only)
- msg_valid_i  input  1  message block offered
- msg_data_i  input  128  block, byte 0 at [7:0]
- msg_bytes_i  input  5  valid bytes, 0..16
- msg_last_i  input  1  final block of message
- msg_ready_o  output  1  block accepted this cycle
- pb_start_o  output  1  one-cycle start pulse to processblock
- pb_r_o  output  128  clamped r
- pb_m_o  output  129  padded block
- pb_a_o  output  130  accumulator into core
- pb_a_i  input  130  accumulator from core
- pb_done_i  input  1  one-cycle done pulse from core
- tag_valid_o  output  1  tag available
- tag_o  output  128  MAC tag, little-endian
- tag_ready_i  input  1  tag consumed
- busy_o  output  1  not in IDLE
- err_o  output  1  sticky protocol or timeout error

Behaviour:
- Reset (async, rst_ni=0):
  - State = IDLE.
  - acc, r, s, and watchdog counter = 0.
  - All outputs 0, except key_ready_o = 1 after reset releases.
  - Asserting reset mid-operation aborts immediately; no tag is produced.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge.
- States:
  - IDLE: key_ready_o = 1. On key transfer:
    - r <= key_i[127:0] & 0x0ffffffc0ffffffc0ffffffc0fffffff
    - s <= key_i[255:128]
    - acc <= 0
    - err_o <= 0
    - go to WAIT_MSG.
  - WAIT_MSG: msg_ready_o = 1. On msg transfer, check the block in this order:
    - msg_bytes_i == 0 with msg_last_i = 1: empty tail; go to FINAL without issuing a multiply.
    - msg_bytes_i > 16, msg_bytes_i == 0 without last, or msg_bytes_i < 16 without last: set err_o, go to IDLE.
    - Otherwise: register padded m, go to ISSUE. Remember msg_last_i.
  - ISSUE: pb_start_o = 1 for exactly one cycle; go to WAIT_PB.
  - WAIT_PB:
    - pb_r_o, pb_m_o, and pb_a_o (= acc) are held stable.
    - On pb_done_i: acc <= pb_a_i; go to FINAL if the block was last, else WAIT_MSG.
    - If the watchdog reaches WDOG_CYCLES without pb_done_i: set err_o, go to IDLE.
  - FINAL (1 cycle):
    - t = acc + 5 (131-bit). If t[130] = 1 then red = t[129:0], else red = acc.
    - tag <= (red[127:0] + s) mod 2^128.
    - Go to TAG.
  - TAG: tag_valid_o = 1; tag_o is held stable until tag_ready_i. On transfer go to IDLE.
- Padding for n = msg_bytes_i:
  - Bits [8n-1:0] = data. Bit 8n = 1. All bits above 8n = 0.
  - For n = 16, bit 128 = 1.
- Latency: the tag is valid 2 cycles after the pb_done_i of the last block (FINAL, then TAG).
- Ignored inputs:
  - pb_done_i outside WAIT_PB is ignored.
  - key_valid_i outside IDLE is ignored.
  - msg_valid_i outside WAIT_MSG is not accepted (msg_ready_o = 0).
- pb_start_o is never reasserted while a multiply is outstanding.
- err_o holds until the next key acceptance or reset.

Decomposition:
- poly1305_pkg holds:
  - constants P = 2^130-5, R_CLAMP_MASK, BLOCK_BYTES = 16
  - widths ACC_W = 130, M_W = 129
  - the state enum typedef: IDLE, WAIT_MSG, ISSUE, WAIT_PB, FINAL, TAG.
- Sub-module poly1305_msg_pad (combinational): data and byte count in; padded 129-bit m and a bad_len flag out.

Test Plan:
- RFC 8439 §2.5.2 vector:
  - Key r-part clamps to 0x0806d5400e52447c036d555408bed685; s = 0x1bf54941aff6bf4afdb20dfb8a800301.
  - Message "Cryptographic Forum Research Group" sent as 16, 16, 2(last) bytes, with a behavioural processblock model.
  - Expect tag bytes a8 06 1d c1 30 51 36 c6 c2 2b 8b af 0c 01 27 a9 and exactly 3 pb_start_o pulses.
- Empty message: key with s = 0x1234, then msg_bytes_i = 0 with last = 1.
  - Expect tag_o = 0x1234 and no pb_start_o pulse.
- Final reduction boundary: model returns pb_a_i = 2^130-3 for a single 16-byte last block, s = 0.
  - Expect tag_o = 2.
  - Repeat with pb_a_i = 2^130-6: expect tag_o = (2^130-6) mod 2^128.
- Tag backpressure: hold tag_ready_i = 0 for 10 cycles.
  - Expect tag_valid_o and tag_o stable and key_ready_o = 0; the state returns to IDLE one cycle after tag_ready_i = 1.
- Errors:
  - msg_bytes_i = 8 without last: expect err_o = 1 and return to IDLE.
  - Core never pulses done: expect err_o = 1 after WDOG_CYCLES cycles.
  - A new key acceptance clears err_o.
- Reset during WAIT_PB: drop rst_ni.
  - Expect all outputs 0 asynchronously, and a later stray pb_done_i is ignored.
